multicycle_control_unit: RTL

- Main control FSM of the 16-bit multi-cycle CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux and enable, plus the 4-bit ALUOp that the downstream ALU control block decodes together with funct.
- Handles the variable-latency memory handshake and counts retired instructions.

---
 rtl/multicycle_control_unit_pkg.sv | 93 +++++++++
 rtl/multicycle_control_unit_inst_class_decode.sv | 35 +++
 rtl/multicycle_control_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle CPU control path: ISA opcodes/functs,
// FSM states, datapath mux selects and the instruction-class vector.
package multicycle_control_unit_pkg;

    localparam logic [3:0] OPCODE_BNE   = 4'd0;
    localparam logic [3:0] OPCODE_BEQ   = 4'd1;
    localparam logic [3:0] OPCODE_BGZ   = 4'd2;
    localparam logic [3:0] OPCODE_BLZ   = 4'd3;
    localparam logic [3:0] OPCODE_ADI   = 4'd4;
    localparam logic [3:0] OPCODE_ORI   = 4'd5;
    localparam logic [3:0] OPCODE_LHI   = 4'd6;
    localparam logic [3:0] OPCODE_LWD   = 4'd7;
    localparam logic [3:0] OPCODE_SWD   = 4'd8;
    localparam logic [3:0] OPCODE_JMP   = 4'd9;
    localparam logic [3:0] OPCODE_JAL   = 4'd10;
    localparam logic [3:0] OPCODE_RTYPE = 4'd15;

    localparam logic [5:0] FUNC_ADD = 6'd0;
    localparam logic [5:0] FUNC_SUB = 6'd1;
    localparam logic [5:0] FUNC_AND = 6'd2;
    localparam logic [5:0] FUNC_ORR = 6'd3;
    localparam logic [5:0] FUNC_NOT = 6'd4;
    localparam logic [5:0] FUNC_TCP = 6'd5;
    localparam logic [5:0] FUNC_SHL = 6'd6;
    localparam logic [5:0] FUNC_SHR = 6'd7;
    localparam logic [5:0] FUNC_JPR = 6'd25;
    localparam logic [5:0] FUNC_JRL = 6'd26;
    localparam logic [5:0] FUNC_WWD = 6'd28;
    localparam logic [5:0] FUNC_HLT = 6'd29;

    typedef enum logic [2:0] {
        S_RST = 3'd0,
        S_IF  = 3'd1,
        S_ID  = 3'd2,
        S_EX  = 3'd3,
        S_MEM = 3'd4,
        S_WB  = 3'd5,
        S_HLT = 3'd6
    } state_t;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_REGA   = 2'd3;

    localparam logic [1:0] ALU_B_REGB = 2'd0;
    localparam logic [1:0] ALU_B_ONE  = 2'd1;
    localparam logic [1:0] ALU_B_IMM  = 2'd2;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_R2 = 2'd2;

    localparam logic [1:0] WB_SRC_ALUOUT = 2'd0;
    localparam logic [1:0] WB_SRC_MDR    = 2'd1;
    localparam logic [1:0] WB_SRC_PC     = 2'd2;

    typedef struct packed {
        logic alu_r;
        logic alu_i;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic jump_link;
        logic jump_reg;
        logic jump_reg_link;
        logic wwd;
        logic halt;
        logic illegal;
    } inst_class_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wb_src;
        logic       wwd_valid;
        logic       inst_done;
        logic       illegal_inst;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_inst_class_decode.sv
// Combinational opcode/funct classifier; exactly one class bit is set for any input.
module multicycle_control_unit_inst_class_decode
    import multicycle_control_unit_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [5:0]  funct,
    output inst_class_t inst_class
);

    always_comb begin
        // NOTE: default every field first so no path through the case leaves a latch.
        inst_class = '0;
        case (opcode)
            OPCODE_BNE, OPCODE_BEQ, OPCODE_BGZ, OPCODE_BLZ: inst_class.branch = 1'b1;
            OPCODE_ADI, OPCODE_ORI, OPCODE_LHI:             inst_class.alu_i  = 1'b1;
            OPCODE_LWD:                                     inst_class.load   = 1'b1;
            OPCODE_SWD:                                     inst_class.store  = 1'b1;
            OPCODE_JMP:                                     inst_class.jump   = 1'b1;
            OPCODE_JAL:                                     inst_class.jump_link = 1'b1;
            OPCODE_RTYPE: begin
                case (funct)
                    FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_ORR,
                    FUNC_NOT, FUNC_TCP, FUNC_SHL, FUNC_SHR: inst_class.alu_r         = 1'b1;
                    FUNC_JPR:                               inst_class.jump_reg      = 1'b1;
                    FUNC_JRL:                               inst_class.jump_reg_link = 1'b1;
                    FUNC_WWD:                               inst_class.wwd           = 1'b1;
                    FUNC_HLT:                               inst_class.halt          = 1'b1;
                    default:                                inst_class.illegal       = 1'b1;
                endcase
            end
            default: inst_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the 16-bit multi-cycle CPU: sequences IF/ID/EX/MEM/WB,
// drives datapath selects/enables and counts retired instructions.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int NUM_INST_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  branch_cond,
    input  logic                  mem_ack,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  i_or_d,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic [1:0]            pc_source,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [3:0]            alu_op,
    output logic                  reg_write,
    output logic [1:0]            reg_dst,
    output logic [1:0]            wb_src,
    output logic                  wwd_valid,
    output logic                  inst_done,
    output logic                  illegal_inst,
    output logic                  halted,
    output logic [NUM_INST_W-1:0] num_inst
);

    state_t                state_q, state_d;
    logic [NUM_INST_W-1:0] num_inst_q, num_inst_d;
    inst_class_t           cls;
    ctrl_t                 ctrl;
    logic                  id_retire;

    // The datapath ANDs pc_write_cond with branch_cond; the FSM never needs it.
    logic unused_branch_cond;
    assign unused_branch_cond = branch_cond;

    multicycle_control_unit_inst_class_decode u_inst_class_decode (
        .opcode     (opcode),
        .funct      (funct),
        .inst_class (cls)
    );

    assign id_retire = cls.jump | cls.jump_link | cls.jump_reg | cls.jump_reg_link
                     | cls.halt | cls.illegal;

    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        case (state_q)
            S_RST: state_d = S_IF;
            S_IF: begin
                ctrl.mem_read = 1'b1;
                if (mem_ack) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PC_SRC_ALU;
                    ctrl.alu_src_b = ALU_B_ONE;
                    ctrl.alu_op    = OPCODE_ADI;
                    state_d        = S_ID;
                end
            end
            S_ID: begin
                // Speculatively compute the branch target into ALUOut.
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = OPCODE_ADI;
                if (cls.jump | cls.jump_link) begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PC_SRC_JUMP;
                end
                if (cls.jump_reg | cls.jump_reg_link) begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PC_SRC_REGA;
                end
                if (cls.jump_link | cls.jump_reg_link) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = REG_DST_R2;
                    ctrl.wb_src    = WB_SRC_PC;
                end
                ctrl.illegal_inst = cls.illegal;
                ctrl.inst_done    = id_retire;
                if (cls.halt)       state_d = S_HLT;
                else if (id_retire) state_d = S_IF;
                else                state_d = S_EX;
            end
            S_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = opcode;
                ctrl.alu_src_b = (opcode == OPCODE_RTYPE) ? ALU_B_REGB : ALU_B_IMM;
                if (cls.branch) begin
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PC_SRC_ALUOUT;
                    ctrl.inst_done     = 1'b1;
                    state_d            = S_IF;
                end else if (cls.wwd) begin
                    ctrl.wwd_valid = 1'b1;
                    ctrl.inst_done = 1'b1;
                    state_d        = S_IF;
                end else if (cls.load | cls.store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_read  = cls.load;
                ctrl.mem_write = cls.store;
                if (mem_ack) begin
                    ctrl.inst_done = cls.store;
                    state_d        = cls.store ? S_IF : S_WB;
                end
            end
            S_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = cls.alu_r ? REG_DST_RD : REG_DST_RT;
                ctrl.wb_src    = cls.load  ? WB_SRC_MDR : WB_SRC_ALUOUT;
                ctrl.inst_done = 1'b1;
                state_d        = S_IF;
            end
            S_HLT:   ctrl.halted = 1'b1;
            default: state_d = S_RST;
        endcase
    end

    always_comb num_inst_d = num_inst_q + NUM_INST_W'(ctrl.inst_done);

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            state_q    <= S_RST;
            num_inst_q <= '0;
        end else begin
            state_q    <= state_d;
            num_inst_q <= num_inst_d;
        end
    end

    // Outputs decode from the registered state, so reset clears them immediately.
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign i_or_d        = ctrl.i_or_d;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign wb_src        = ctrl.wb_src;
    assign wwd_valid     = ctrl.wwd_valid;
    assign inst_done     = ctrl.inst_done;
    assign illegal_inst  = ctrl.illegal_inst;
    assign halted        = ctrl.halted;
    assign num_inst      = num_inst_q;

endmodule
